wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Writeback stage feeding the register-file write port. Arbitrates results from the
//   single-cycle ALU and the variable-latency load/store unit (LSU) onto one registered
//   write port (wr_port_o/wr_data_o/ctrl_reg_wr_en_o). Keeps a per-register scoreboard of
//   outstanding writes so decode can stall on rs1/rs2 RAW hazards.
// PARAMETERS
//   XLEN          32  data width
//   PEND_W        2   width of per-register pending counter (max 2^PEND_W-1 in flight)
//   STARVE_LIMIT  4   consecutive ALU-lost arbitrations before ALU is forced to win
// PORTS
//   clk               in   1     clock
//   rst_n             in   1     asynchronous active-low reset
//   issue_valid_i     in   1     decode issues an instruction writing issue_rd_i
//   issue_rd_i        in   5     destination register of issued instruction
//   issue_ready_o     out  1     0 when issue_rd_i pending counter is saturated
//   rs1_i, rs2_i      in   5     source registers queried by decode
//   rs1_busy_o        out  1     rs1_i has an outstanding or in-flight write
//   rs2_busy_o        out  1     rs2_i has an outstanding or in-flight write
//   alu_valid_i       in   1     ALU result valid
//   alu_ready_o       out  1     ALU result accepted this cycle
//   alu_rd_i          in   5     ALU destination register
//   alu_data_i        in   XLEN  ALU result
//   lsu_valid_i       in   1     LSU result valid
//   lsu_ready_o       out  1     LSU result accepted this cycle
//   lsu_rd_i          in   5     LSU destination register
//   lsu_data_i        in   XLEN  LSU result
//   wr_port_o         out  5     register-file write address
//   wr_data_o         out  XLEN  register-file write data
//   ctrl_reg_wr_en_o  out  1     register-file write enable
//   sb_err_o          out  1     sticky: retire to a register with zero pending count
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low (clk, rst_n). Reset clears all
//     pending counters, starve counter, wr_port_o/wr_data_o/ctrl_reg_wr_en_o, sb_err_o to 0.
//   - Handshake: transfer when valid&&ready. valid must not depend on ready; ready is
//     combinational from both valids and the starve counter. Source holds rd/data stable
//     while valid&&!ready.
//   - Arbitration: LSU wins by default. ALU wins if only ALU valid, or if starve
//     counter == STARVE_LIMIT. Starve counter increments each cycle ALU valid and loses,
//     clears to 0 when ALU is granted or ALU not valid; saturates at STARVE_LIMIT.
//   - Output latency: accepted result appears on wr_port_o/wr_data_o with
//     ctrl_reg_wr_en_o=1 exactly one cycle after the handshake cycle. No acceptance ->
//     ctrl_reg_wr_en_o=0 next cycle; wr_port_o/wr_data_o hold last value.
//   - x0: accepted result with rd==0 is consumed (ready asserted) but produces
//     ctrl_reg_wr_en_o=0 and no scoreboard change. issue with rd==0 ignored; x0 never busy.
//   - Scoreboard: cnt[r] +1 on issue handshake (issue_valid_i&&issue_ready_o), -1 on
//     result handshake for r. Issue and retire to same r in one cycle -> cnt unchanged.
//     issue_ready_o=0 when cnt[issue_rd_i] is all-ones (unless a retire to the same r is
//     accepted that cycle, then 1).
//   - Retire to r with cnt[r]==0: cnt stays 0, write still performed, sb_err_o set; only
//     reset clears it.
//   - rsN_busy_o = (cnt[rsN]!=0) || (ctrl_reg_wr_en_o && wr_port_o==rsN), rsN!=0.
//     Combinational; the in-flight term covers the cycle the regfile is being written.
//   - Reset mid-operation: in-flight write dropped (ctrl_reg_wr_en_o forced 0 immediately).
// TESTING
//   1 Reset: assert rst_n=0 mid-write -> ctrl_reg_wr_en_o=0 at once, all busy=0, sb_err_o=0.
//   2 Issue rd=5; ALU valid rd=5 data=0xDEADBEEF -> next cycle wr_port_o=5,
//     wr_data_o=0xDEADBEEF, en=1; rs1_i=5 busy=1 until the cycle after the write, then 0.
//   3 ALU and LSU both valid every cycle (STARVE_LIMIT=4) -> LSU granted 4 cycles, ALU
//     granted on the 5th, pattern repeats; no result lost or duplicated.
//   4 Issue rd=7 three times (PEND_W=2) -> issue_ready_o=0 for the 4th issue; with a
//     retire to 7 in the same cycle -> issue_ready_o=1, cnt stays 3.
//   5 ALU valid rd=0 data=0x1234 -> alu_ready_o=1, ctrl_reg_wr_en_o=0 next cycle,
//     rs1_busy_o=0 for rs1_i=0.
//   6 LSU retire rd=9 with no prior issue -> write performed, sb_err_o=1 and stays 1.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto one registered regfile write port
// and tracks per-register outstanding writes for decode RAW-hazard stalls.
module wb_arbiter #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PEND_W       = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  input  logic [4:0]      issue_rd_i,
  output logic            issue_ready_o,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  input  logic            alu_valid_i,
  output logic            alu_ready_o,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            lsu_valid_i,
  output logic            lsu_ready_o,
  input  logic [4:0]      lsu_rd_i,
  input  logic [XLEN-1:0] lsu_data_i,
  output logic [4:0]      wr_port_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic            ctrl_reg_wr_en_o,
  output logic            sb_err_o
);

  localparam int unsigned StW = $clog2(STARVE_LIMIT + 1);

  logic [PEND_W-1:0] cnt_q [32];
  logic [PEND_W-1:0] cnt_d [32];
  logic [StW-1:0]    starve_q, starve_d;
  logic              err_d;

  logic              alu_win, lsu_win, ret_valid, ret_fire, issue_fire;
  logic [4:0]        ret_rd;
  logic [XLEN-1:0]   ret_data;
  logic [31:0]       inc_vec, dec_vec;

  // LSU has priority unless the ALU has been starved long enough.
  always_comb begin
    alu_win   = alu_valid_i && (!lsu_valid_i || (starve_q == StW'(STARVE_LIMIT)));
    lsu_win   = lsu_valid_i && !alu_win;
    ret_valid = alu_win || lsu_win;
    ret_rd    = alu_win ? alu_rd_i : lsu_rd_i;
    ret_data  = alu_win ? alu_data_i : lsu_data_i;
    ret_fire  = ret_valid && (ret_rd != 5'd0);
  end

  assign alu_ready_o = alu_win;
  assign lsu_ready_o = lsu_win;

  always_comb begin
    starve_d = '0;
    if (alu_valid_i && !alu_win) begin
      starve_d = (starve_q == StW'(STARVE_LIMIT)) ? starve_q : starve_q + StW'(1);
    end
  end

  // A retire to the same register frees a slot in the same cycle.
  assign issue_ready_o = (cnt_q[issue_rd_i] != {PEND_W{1'b1}}) ||
                         (ret_fire && (ret_rd == issue_rd_i));
  assign issue_fire    = issue_valid_i && issue_ready_o && (issue_rd_i != 5'd0);

  always_comb begin
    inc_vec = issue_fire ? (32'd1 << issue_rd_i) : 32'd0;
    dec_vec = ret_fire ? (32'd1 << ret_rd) : 32'd0;
    err_d   = sb_err_o;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (dec_vec[r] && (cnt_q[r] == '0)) begin
        err_d = 1'b1;
      end
      if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + PEND_W'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
      starve_q         <= '0;
      wr_port_o        <= '0;
      wr_data_o        <= '0;
      ctrl_reg_wr_en_o <= 1'b0;
      sb_err_o         <= 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      starve_q         <= starve_d;
      sb_err_o         <= err_d;
      ctrl_reg_wr_en_o <= ret_fire;
      if (ret_fire) begin
        wr_port_o <= ret_rd;
        wr_data_o <= ret_data;
      end
    end
  end

  // The in-flight term covers the cycle the regfile write is actually happening.
  assign rs1_busy_o = (rs1_i != 5'd0) &&
                      ((cnt_q[rs1_i] != '0) || (ctrl_reg_wr_en_o && (wr_port_o == rs1_i)));
  assign rs2_busy_o = (rs2_i != 5'd0) &&
                      ((cnt_q[rs2_i] != '0) || (ctrl_reg_wr_en_o && (wr_port_o == rs2_i)));

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, basic write, starvation, saturation, x0, sb_err.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_ready_o;
  logic [4:0]  rs1_i, rs2_i;
  logic        rs1_busy_o, rs2_busy_o;
  logic        alu_valid_i, alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i, lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic [4:0]  wr_port_o;
  logic [31:0] wr_data_o;
  logic        ctrl_reg_wr_en_o;
  logic        sb_err_o;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.XLEN(32), .PEND_W(2), .STARVE_LIMIT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid_i   (issue_valid_i),
    .issue_rd_i      (issue_rd_i),
    .issue_ready_o   (issue_ready_o),
    .rs1_i           (rs1_i),
    .rs2_i           (rs2_i),
    .rs1_busy_o      (rs1_busy_o),
    .rs2_busy_o      (rs2_busy_o),
    .alu_valid_i     (alu_valid_i),
    .alu_ready_o     (alu_ready_o),
    .alu_rd_i        (alu_rd_i),
    .alu_data_i      (alu_data_i),
    .lsu_valid_i     (lsu_valid_i),
    .lsu_ready_o     (lsu_ready_o),
    .lsu_rd_i        (lsu_rd_i),
    .lsu_data_i      (lsu_data_i),
    .wr_port_o       (wr_port_o),
    .wr_data_o       (wr_data_o),
    .ctrl_reg_wr_en_o(ctrl_reg_wr_en_o),
    .sb_err_o        (sb_err_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    issue_valid_i = 1'b0; issue_rd_i = '0;
    alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
    lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rs1_i = '0; rs2_i = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    issue_valid_i = 1'b1; issue_rd_i = 5'd4;
    tick();
    tick();
    issue_valid_i = 1'b0;
    // Retire to x3 with nothing pending: sets sb_err and produces a write.
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd3; lsu_data_i = 32'h0000_0033;
    tick();
    idle_inputs();
    rs1_i = 5'd3; rs2_i = 5'd4;
    #1;
    total++;
    if (ctrl_reg_wr_en_o !== 1'b1 || sb_err_o !== 1'b1 || rs2_busy_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre: en=%b err=%b busy2=%b required 1 1 1",
               ctrl_reg_wr_en_o, sb_err_o, rs2_busy_o);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (ctrl_reg_wr_en_o !== 1'b0 || sb_err_o !== 1'b0 || rs1_busy_o !== 1'b0 ||
        rs2_busy_o !== 1'b0 || wr_port_o !== 5'd0 || wr_data_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_async: en=%b err=%b busy1=%b busy2=%b port=%0d data=%h required all 0",
               ctrl_reg_wr_en_o, sb_err_o, rs1_busy_o, rs2_busy_o, wr_port_o, wr_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_write();
    do_reset();
    rs1_i = 5'd5;
    issue_valid_i = 1'b1; issue_rd_i = 5'd5;
    #1;
    total++;
    if (issue_ready_o !== 1'b1) begin
      bad++; $display("FAIL basic_issue_ready: got %b required 1", issue_ready_o);
    end
    tick();
    issue_valid_i = 1'b0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEAD_BEEF;
    #1;
    total++;
    if (rs1_busy_o !== 1'b1 || alu_ready_o !== 1'b1) begin
      bad++; $display("FAIL basic_pending: busy=%b ready=%b required 1 1", rs1_busy_o, alu_ready_o);
    end
    tick();
    alu_valid_i = 1'b0;
    #1;
    total++;
    if (ctrl_reg_wr_en_o !== 1'b1 || wr_port_o !== 5'd5 || wr_data_o !== 32'hDEAD_BEEF ||
        rs1_busy_o !== 1'b1) begin
      bad++;
      $display("FAIL basic_write: en=%b port=%0d data=%h busy=%b required 1 5 deadbeef 1",
               ctrl_reg_wr_en_o, wr_port_o, wr_data_o, rs1_busy_o);
    end
    tick();
    total++;
    if (ctrl_reg_wr_en_o !== 1'b0 || rs1_busy_o !== 1'b0 || wr_data_o !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL basic_after: en=%b busy=%b data=%h required 0 0 deadbeef",
               ctrl_reg_wr_en_o, rs1_busy_o, wr_data_o);
    end
  endtask

  task automatic test_starve();
    int ai = 0;
    int li = 0;
    logic exp_alu;
    logic [31:0] exp_data;
    logic [4:0] exp_port;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      alu_valid_i = 1'b1; alu_rd_i = 5'd10; alu_data_i = 32'hA000_0000 + 32'(ai);
      lsu_valid_i = 1'b1; lsu_rd_i = 5'd11; lsu_data_i = 32'hB000_0000 + 32'(li);
      #1;
      exp_alu  = ((k % 5) == 4);
      exp_data = exp_alu ? 32'hA000_0000 + 32'(ai) : 32'hB000_0000 + 32'(li);
      exp_port = exp_alu ? 5'd10 : 5'd11;
      total++;
      if (alu_ready_o !== exp_alu || lsu_ready_o !== !exp_alu) begin
        bad++;
        $display("FAIL starve_grant[%0d]: alu=%b lsu=%b required %b %b",
                 k, alu_ready_o, lsu_ready_o, exp_alu, !exp_alu);
      end
      tick();
      total++;
      if (ctrl_reg_wr_en_o !== 1'b1 || wr_data_o !== exp_data || wr_port_o !== exp_port) begin
        bad++;
        $display("FAIL starve_data[%0d]: en=%b port=%0d data=%h required 1 %0d %h",
                 k, ctrl_reg_wr_en_o, wr_port_o, wr_data_o, exp_port, exp_data);
      end
      if (exp_alu) ai++; else li++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue_valid_i = 1'b1; issue_rd_i = 5'd7;
      #1;
      total++;
      if (issue_ready_o !== 1'b1) begin
        bad++; $display("FAIL sat_issue[%0d]: got %b required 1", i, issue_ready_o);
      end
      tick();
    end
    #1;
    total++;
    if (issue_ready_o !== 1'b0) begin
      bad++; $display("FAIL sat_full: got %b required 0", issue_ready_o);
    end
    alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h0000_0777;
    #1;
    total++;
    if (issue_ready_o !== 1'b1 || alu_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL sat_same_cycle: issue_ready=%b alu_ready=%b required 1 1",
               issue_ready_o, alu_ready_o);
    end
    tick();
    alu_valid_i = 1'b0;
    #1;
    // Count must still be 3: issue is blocked again without a retire.
    total++;
    if (issue_ready_o !== 1'b0 || sb_err_o !== 1'b0) begin
      bad++;
      $display("FAIL sat_still_full: issue_ready=%b err=%b required 0 0", issue_ready_o, sb_err_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_x0();
    do_reset();
    rs1_i = 5'd0;
    issue_valid_i = 1'b1; issue_rd_i = 5'd0;
    alu_valid_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 32'h0000_1234;
    #1;
    total++;
    if (alu_ready_o !== 1'b1 || rs1_busy_o !== 1'b0) begin
      bad++; $display("FAIL x0_accept: ready=%b busy=%b required 1 0", alu_ready_o, rs1_busy_o);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (ctrl_reg_wr_en_o !== 1'b0 || rs1_busy_o !== 1'b0 || sb_err_o !== 1'b0) begin
      bad++;
      $display("FAIL x0_no_write: en=%b busy=%b err=%b required 0 0 0",
               ctrl_reg_wr_en_o, rs1_busy_o, sb_err_o);
    end
  endtask

  task automatic test_sb_err();
    do_reset();
    total++;
    if (sb_err_o !== 1'b0) begin
      bad++; $display("FAIL sberr_init: got %b required 0", sb_err_o);
    end
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h5555_AAAA;
    #1;
    total++;
    if (lsu_ready_o !== 1'b1) begin
      bad++; $display("FAIL sberr_ready: got %b required 1", lsu_ready_o);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (ctrl_reg_wr_en_o !== 1'b1 || wr_port_o !== 5'd9 || wr_data_o !== 32'h5555_AAAA ||
        sb_err_o !== 1'b1) begin
      bad++;
      $display("FAIL sberr_write: en=%b port=%0d data=%h err=%b required 1 9 5555aaaa 1",
               ctrl_reg_wr_en_o, wr_port_o, wr_data_o, sb_err_o);
    end
    repeat (3) tick();
    total++;
    if (sb_err_o !== 1'b1) begin
      bad++; $display("FAIL sberr_sticky: got %b required 1", sb_err_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    rs1_i = '0; rs2_i = '0;
    test_reset();
    test_basic_write();
    test_starve();
    test_saturate();
    test_x0();
    test_sb_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
